// File: rtl/rca_shift_add_mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared types and constants for the shift-and-add multiplier controller.
//   state_t    : controller states IDLE/RUN/DONE with their fixed 2-bit encoding
//   DEF_WIDTH  : default operand width
//   cnt_w()    : iteration counter width able to hold the value WIDTH
package mult_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 8;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/rca_shift_add_mult_ctrl_if.sv
// rca_shift_add_mult_ctrl_if: start/busy/done handshake and operand/result bus.
//   start   : launch request (host -> controller)
//   a, b    : multiplicand / multiplier (host -> controller)
//   busy    : iteration in progress (controller -> host)
//   done    : one-cycle completion pulse (controller -> host)
//   product : 2*WIDTH-bit result register (controller -> host)
//   master  : host view; slave : controller view
interface rca_shift_add_mult_ctrl_if #(parameter int WIDTH = 8);

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/rca_shift_add_mult_ctrl_add_stage_w.sv
// add_stage_w: combinational WIDTH-bit ripple-carry adder.
//   a, b  : addends
//   c_in  : carry into bit 0
//   s     : sum
//   c_out : carry out of the MSB
module add_stage_w #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   always_comb begin
      logic cy;
      s  = '0;
      cy = c_in;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = a[i] ^ b[i] ^ cy;
         cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      c_out = cy;
   end

endmodule

// File: rtl/rca_shift_add_mult_ctrl.sv
// rca_shift_add_mult_ctrl: sequential unsigned shift-and-add multiplier sharing one ripple adder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rca_shift_add_mult_ctrl_if (start, a, b, busy, done, product)
//   Optional macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module rca_shift_add_mult_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   rca_shift_add_mult_ctrl_if.slave bus
);

   localparam int CNT_W = cnt_w(WIDTH);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 cout;

   assign addend = q_q[0] ? m_q : '0;

   add_stage_w #(.WIDTH(WIDTH)) u_add (
      .a     (acc_q),
      .b     (addend),
      .c_in  (1'b0),
      .s     (sum),
      .c_out (cout)
   );

`ifdef EARLY_TERM_EN
   // The low count_q bits of Q are the multiplier bits not yet consumed;
   // once they are all zero the remaining iterations are pure shifts.
   logic [WIDTH-1:0]   live_mask;
   logic               early;
   logic [2*WIDTH-1:0] shifted;
   assign live_mask = ~({WIDTH{1'b1}} << count_q);
   assign early     = (q_q & live_mask) == '0;
   assign shifted   = {acc_q, q_q} >> count_q;
`endif

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = RUN;
            m_d     = bus.a;
            q_d     = bus.b;
            acc_d   = '0;
            count_d = CNT_W'(WIDTH);
         end
         RUN: begin
`ifdef EARLY_TERM_EN
            if (early) begin
               state_d   = DONE;
               product_d = shifted;
               count_d   = '0;
            end else begin
`else
            begin
`endif
               // Carry-out becomes the new ACC MSB; the sum LSB moves into Q.
               acc_d   = {cout, sum[WIDTH-1:1]};
               q_d     = {sum[0], q_q[WIDTH-1:1]};
               count_d = count_q - 1'b1;
               if (count_q == CNT_W'(1)) begin
                  state_d   = DONE;
                  product_d = {cout, sum, q_q[WIDTH-1:1]};
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = state_q == RUN;
   assign bus.done    = state_q == DONE;
   assign bus.product = product_q;

endmodule

// File: tb/tb_rca_shift_add_mult_ctrl.sv
// tb_rca_shift_add_mult_ctrl: randomized self-checking bench against a plain a*b reference.
module tb_rca_shift_add_mult_ctrl;

   localparam int W = 8;
`ifdef EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [2*W-1:0] prev_prod = '0;

   always #5 clk = ~clk;

   rca_shift_add_mult_ctrl_if #(.WIDTH(W)) bus ();

   rca_shift_add_mult_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [W-1:0] bv);
      int h = -1;
      for (int i = 0; i < W; i++) if (bv[i]) h = i;
      if (!ET) return W;
      if (h < 0) return 1;
      return (h + 2 < W) ? h + 2 : W;
   endfunction

   // Called at a negedge while the controller is IDLE; returns at the negedge
   // of the IDLE cycle that follows done.
   task automatic run_mult(input logic [W-1:0] ta, input logic [W-1:0] tbv, input bit poke);
      int lat = 0;
      logic [2*W-1:0] exp_p;
      exp_p = (2*W)'(ta) * (2*W)'(tbv);
      bus.a = ta;
      bus.b = tbv;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      check("prod_held_in_run", bus.product, prev_prod);
      while (!bus.done && lat < 40) begin
         check("busy_in_run", bus.busy, 1);
         if (poke && lat == 2) begin
            bus.start = 1'b1;
            bus.a = 1;
            bus.b = 1;
         end else bus.start = 1'b0;
         lat++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("done_seen", bus.done, 1);
      check("latency", lat, exp_lat(tbv));
      check("busy_in_done", bus.busy, 0);
      check("product", bus.product, exp_p);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("product_kept", bus.product, exp_p);
      prev_prod = exp_p;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_product", bus.product, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_mult(8'd13, 8'd11, 1'b0);
      run_mult(8'd255, 8'd255, 1'b0);
      run_mult(8'd77, 8'd200, 1'b1);
      run_mult(8'd1, 8'd1, 1'b0);
      // Reset in the middle of a 200*3 operation.
      bus.a = 8'd200;
      bus.b = 8'd3;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_product", bus.product, 0);
      prev_prod = '0;
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_done", bus.done, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_mult(8'd7, 8'd6, 1'b0);
      run_mult(8'd0, 8'd173, 1'b0);
      run_mult(8'd91, 8'd0, 1'b0);
      run_mult(8'd200, 8'd3, 1'b0);
      run_mult(8'd255, 8'd128, 1'b0);
      for (int n = 0; n < 500; n++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 9) == 0) ra = ($urandom_range(0, 1) == 0) ? '0 : '1;
         if ($urandom_range(0, 9) == 0) rb = ($urandom_range(0, 1) == 0) ? '0 : '1;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, W - 1);
         run_mult(ra, rb, $urandom_range(0, 7) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
